// File: rtl/led_mode_ctrl.sv
// Four-LED pattern controller with debounced mode and pause/restart buttons.
// Define LED_PAUSE_EN to build the pause key and the PAUSE/DONE restart path.

module led_key_db #(
  parameter logic [19:0] DEBOUNCE_CNT = 20'd1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);
  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic        r_press;
  logic [19:0] r_cnt;

  assign o_press = r_press;

  // The counter only runs while the synced level disagrees with the accepted level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DEBOUNCE_CNT - 20'd1) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end
endmodule

module led_mode_ctrl #(
  parameter logic [23:0] TICK_CNT     = 24'd10_000_000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_mode_n,
  input  logic       key_pause_n,
  output logic [3:0] led,
  output logic [1:0] mode
);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] M_FLOW_L = 2'd0;
  localparam logic [1:0] M_FLOW_R = 2'd1;
  localparam logic [1:0] M_DECR   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_mode;
  logic [3:0]  r_led;
  logic [23:0] r_tick_cnt;
  logic        w_mode_press;
  logic        w_tick;
  logic [1:0]  w_mode_nxt;
  logic [3:0]  w_init_led;
  logic [3:0]  w_step_led;

  assign led  = r_led;
  assign mode = r_mode;

  led_key_db #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_mode (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_key_n (key_mode_n),
    .o_press (w_mode_press)
  );

`ifdef LED_PAUSE_EN
  localparam logic [1:0] ST_PAUSE = 2'd1;
  logic w_pause_press;

  led_key_db #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_pause (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_key_n (key_pause_n),
    .o_press (w_pause_press)
  );
`else
  logic w_unused_pause;
  assign w_unused_pause = key_pause_n;
`endif

  assign w_mode_nxt = r_mode + 2'd1;
  assign w_tick     = (r_state == ST_RUN) && (r_tick_cnt == TICK_CNT - 24'd1);

  always_comb begin
    w_init_led = 4'b1111;
    case (w_mode_nxt)
      M_FLOW_L: w_init_led = 4'b0001;
      M_FLOW_R: w_init_led = 4'b1000;
      default:  w_init_led = 4'b1111;
    endcase
  end

  always_comb begin
    w_step_led = ~r_led;
    case (r_mode)
      M_FLOW_L: w_step_led = {r_led[2:0], r_led[3]};
      M_FLOW_R: w_step_led = {r_led[0], r_led[3:1]};
      M_DECR:   w_step_led = {1'b0, r_led[3:1]};
      default:  w_step_led = ~r_led;
    endcase
  end

  // Priority: mode press, then pause press, then the tick step
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_RUN;
      r_mode     <= M_FLOW_L;
      r_led      <= 4'b0001;
      r_tick_cnt <= '0;
    end else if (w_mode_press) begin
      r_mode     <= w_mode_nxt;
      r_led      <= w_init_led;
      r_tick_cnt <= '0;
      r_state    <= ST_RUN;
`ifdef LED_PAUSE_EN
    end else if (w_pause_press) begin
      case (r_state)
        ST_RUN:   r_state <= ST_PAUSE;
        ST_PAUSE: r_state <= ST_RUN;
        default: begin
          r_state    <= ST_RUN;
          r_led      <= 4'b1111;
          r_tick_cnt <= '0;
        end
      endcase
`endif
    end else if (r_state == ST_RUN) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 24'd1;
      if (w_tick) begin
        r_led <= w_step_led;
        if (r_mode == M_DECR && w_step_led == 4'b0000) begin
          r_state <= ST_DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_CNT=4, DEBOUNCE_CNT=3.
// Pause expectations follow whether LED_PAUSE_EN is defined for this build.

module tb_led_mode_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_mode_n;
  logic       key_pause_n;
  logic [3:0] led;
  logic [1:0] mode;

  int n_vec = 0;
  int n_err = 0;

  led_mode_ctrl #(.TICK_CNT(24'd4), .DEBOUNCE_CNT(20'd3)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_mode_n  (key_mode_n),
    .key_pause_n (key_pause_n),
    .led         (led),
    .mode        (mode)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Key low for 6 cycles: sync(2) + debounce(3) + event register -> acts on the 6th edge
  task automatic press_mode();
    key_mode_n = 1'b0;
    cyc(6);
    key_mode_n = 1'b1;
  endtask

  task automatic press_pause();
    key_pause_n = 1'b0;
    cyc(6);
    key_pause_n = 1'b1;
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    key_mode_n  = 1'b1;
    key_pause_n = 1'b1;
    cyc(3);
    chk("reset_led", led, 4'b0001);
    chk("reset_mode", {2'b00, mode}, 4'd0);

    sys_rst_n = 1'b1;
    cyc(3);  chk("flowl_hold", led, 4'b0001);
    cyc(1);  chk("flowl_1", led, 4'b0010);
    cyc(4);  chk("flowl_2", led, 4'b0100);
    cyc(4);  chk("flowl_3", led, 4'b1000);
    cyc(4);  chk("flowl_wrap", led, 4'b0001);
    chk("flowl_mode", {2'b00, mode}, 4'd0);

    press_mode();
    chk("m1_mode", {2'b00, mode}, 4'd1);
    chk("m1_led", led, 4'b1000);
    cyc(4);  chk("m1_step", led, 4'b0100);
    cyc(2);

    press_mode();
    chk("m2_mode", {2'b00, mode}, 4'd2);
    chk("m2_led", led, 4'b1111);
    cyc(4);  chk("decr_1", led, 4'b0111);
    cyc(4);  chk("decr_2", led, 4'b0011);
    cyc(4);  chk("decr_3", led, 4'b0001);
    cyc(4);  chk("decr_4", led, 4'b0000);
    cyc(8);  chk("done_hold", led, 4'b0000);

    press_pause();
`ifdef LED_PAUSE_EN
    chk("done_restart", led, 4'b1111);
    cyc(4);  chk("restart_step", led, 4'b0111);
`else
    chk("pause_ignored", led, 4'b0000);
    cyc(4);  chk("pause_ignored_2", led, 4'b0000);
`endif
    cyc(2);

    press_mode();
    chk("m3_mode", {2'b00, mode}, 4'd3);
    chk("m3_led", led, 4'b1111);
    cyc(4);  chk("blink_step", led, 4'b0000);
    cyc(2);

    press_mode();
    chk("m0_mode", {2'b00, mode}, 4'd0);
    chk("m0_led", led, 4'b0001);
    cyc(4);  chk("m0_step", led, 4'b0010);
    cyc(2);

`ifdef LED_PAUSE_EN
    // Pause edge lands on a tick edge: the step to 1000 must be discarded
    press_pause();
    chk("pause_on_tick", led, 4'b0100);
    cyc(20); chk("pause_frozen", led, 4'b0100);
    press_pause();
    chk("unpause_edge", led, 4'b0100);
    cyc(4);  chk("unpause_step", led, 4'b1000);
    cyc(2);
`endif

    key_mode_n = 1'b0;
    cyc(2);
    key_mode_n = 1'b1;
    cyc(8);  chk("glitch_mode", {2'b00, mode}, 4'd0);

    key_mode_n = 1'b0;
    cyc(50);
    key_mode_n = 1'b1;
    chk("hold_mode", {2'b00, mode}, 4'd1);
    cyc(10); chk("release_mode", {2'b00, mode}, 4'd1);

    key_mode_n  = 1'b0;
    key_pause_n = 1'b0;
    cyc(6);
    key_mode_n  = 1'b1;
    key_pause_n = 1'b1;
    chk("both_mode", {2'b00, mode}, 4'd2);
    chk("both_led", led, 4'b1111);
    cyc(4);  chk("both_running", led, 4'b0111);
    cyc(1);

    sys_rst_n = 1'b0;
    #1;
    chk("midrst_led", led, 4'b0001);
    chk("midrst_mode", {2'b00, mode}, 4'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc(3);  chk("post_rst_hold", led, 4'b0001);
    cyc(1);  chk("post_rst_tick", led, 4'b0010);
    chk("post_rst_mode", {2'b00, mode}, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter TICK_CNT, default 24'd10_000_000, sys_clk cycles per pattern step (0.2 s at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter DEBOUNCE_CNT, default 20'd1_000_000, cycles a key level must be stable before acceptance (20 ms); legal range 2..2^20-1.
REQ-003 sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 key_mode_n  input  1  mode button, active-low, asynchronous to sys_clk.
REQ-006 key_pause_n  input  1  pause/restart button, active-low, asynchronous to sys_clk.
REQ-007 led  output  4  registered LED drive, 1 = lit.
REQ-008 mode  output  2  registered current mode: 0 FLOW_L, 1 FLOW_R, 2 DECR, 3 BLINK.

Function
REQ-009 Each key passes a 2-flop synchronizer, then a debouncer holding a stable level (reset value 1).
REQ-010 Debounce counter clears when synced level equals stable level; otherwise increments; on reaching DEBOUNCE_CNT-1 the stable level takes the synced level and the counter clears.
REQ-011 Press event is a one-cycle registered pulse on a stable-level 1->0 transition; releases generate no event.
REQ-012 Tick counter counts 0..TICK_CNT-1 only in state RUN, wraps to 0; tick pulse asserted on the cycle count == TICK_CNT-1.
REQ-013 FSM states: RUN, PAUSE, DONE; reset state RUN.
REQ-014 On a tick in RUN, led advances one step on the next edge, per mode:
- FLOW_L: rotate left, 0001->0010->0100->1000->0001.
- FLOW_R: rotate right, 1000->0100->0010->0001->1000.
- DECR: logical shift right, 1111->0111->0011->0001->0000; the step producing 0000 also moves FSM to DONE.
- BLINK: led <= ~led, alternating 1111/0000.
REQ-015 Mode press (any state): mode <= mode+1 (3 wraps to 0), led loads the new mode's initial pattern (FLOW_L 0001, FLOW_R 1000, DECR 1111, BLINK 1111), tick counter clears, FSM -> RUN, all on the same edge.
REQ-016 Pause press: RUN -> PAUSE; PAUSE -> RUN; DONE -> RUN with led <= 1111 and tick counter cleared.
REQ-017 In PAUSE and DONE, tick counter and led hold their values.
REQ-018 Mode press and pause press on the same cycle: mode press acts, pause press is discarded.
REQ-019 Tick and any press on the same cycle: the press acts, the tick step is discarded.
REQ-020 Holding a key low produces exactly one event; glitches shorter than DEBOUNCE_CNT cycles produce none.

Reset
REQ-021 While sys_rst_n is low: led = 4'b0001, mode = 2'd0, FSM = RUN, tick and debounce counters 0, synchronizers and stable levels 1, no event pulses.
REQ-022 Reset mid-sequence discards all progress; after release, operation restarts from REQ-021 values with the first tick TICK_CNT cycles later.

Configuration
REQ-023 Macro LED_PAUSE_EN defined: key_pause_n and PAUSE/DONE restart behave per REQ-016.
REQ-024 LED_PAUSE_EN undefined: key_pause_n port retained but ignored, its synchronizer/debouncer absent, FSM never enters PAUSE, DONE is exited only by mode press or reset.

Verification (TICK_CNT=4, DEBOUNCE_CNT=3, LED_PAUSE_EN defined unless noted)
REQ-025 Release reset, no keys -> led 0001, 0010, 0100, 1000, 0001 at 4-cycle intervals; mode stays 0.
REQ-026 Three mode presses -> mode 1, 2, 3 with led loading 1000, 1111, 1111; fourth press -> mode 0, led 0001.
REQ-027 Mode 2, run 16 cycles -> led 0111, 0011, 0001, 0000 then held in DONE; pause press -> led 1111 and stepping resumes.
REQ-028 Mode 0 pause press -> led frozen 20 cycles; second pause press -> stepping resumes on the next tick.
REQ-029 key_mode_n low pulses of 2 cycles -> no mode change; held low 50 cycles -> exactly one increment; both keys pressed same cycle -> mode increments, FSM stays RUN.
REQ-030 Assert sys_rst_n mid-DECR -> led 0001, mode 0 immediately; macro undefined build -> pause presses have no effect.
